// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and EX forwarding selects.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int CNT_W = 4;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding selects; MEM result has priority over WB, register 0 never forwards.
module forward_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_rs_e,
   input  logic [REG_AW-1:0] i_rt_e,
   input  logic              i_reg_write_m,
   input  logic [REG_AW-1:0] i_write_reg_m,
   input  logic              i_reg_write_w,
   input  logic [REG_AW-1:0] i_write_reg_w,
   output logic [1:0]        o_forward_a,
   output logic [1:0]        o_forward_b
);

   logic w_mem_ok;
   logic w_wb_ok;

   assign w_mem_ok = i_reg_write_m && (i_write_reg_m != '0);
   assign w_wb_ok  = i_reg_write_w && (i_write_reg_w != '0);

   always_comb begin
      o_forward_a = FWD_RF;
      if (w_mem_ok && (i_write_reg_m == i_rs_e))
         o_forward_a = FWD_MEM;
      else if (w_wb_ok && (i_write_reg_w == i_rs_e))
         o_forward_a = FWD_WB;
   end

   always_comb begin
      o_forward_b = FWD_RF;
      if (w_mem_ok && (i_write_reg_m == i_rt_e))
         o_forward_b = FWD_MEM;
      else if (w_wb_ok && (i_write_reg_w == i_rt_e))
         o_forward_b = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard control: load-use stall, branch flush, forwarding, halt-drain FSM.
// Optional PIPE_PERF_CNT_EN adds stall_count/flush_count performance counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4,
   parameter int REG_AW       = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs_address_d,
   input  logic [REG_AW-1:0] rt_address_d,
   input  logic              uses_rt_d,
   input  logic              branch_taken_d,
   input  logic              halt_d,
   input  logic [REG_AW-1:0] rs_address_e,
   input  logic [REG_AW-1:0] rt_address_e,
   input  logic              mem_read_e,
   input  logic              reg_write_e,
   input  logic [REG_AW-1:0] write_reg_e,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] write_reg_m,
   input  logic              reg_write_w,
   input  logic [REG_AW-1:0] write_reg_w,
   output logic              sig_stall,
   output logic              pc_hold,
   output logic              sig_flush,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              cpu_halted
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]       stall_count,
   output logic [31:0]       flush_count
`endif
);

   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_drain_cnt;
   logic [CNT_W-1:0] w_next_cnt;
   logic             r_cpu_halted;
   logic             w_load_use;
   logic             w_stall;
   logic             w_hold;
   logic             w_flush;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;
   logic             w_unused_rw_e;

   // reg_write_e is implied by mem_read_e for a load; it does not gate the hazard.
   assign w_unused_rw_e = reg_write_e;

   assign w_load_use = mem_read_e && (write_reg_e != '0) &&
                       ((write_reg_e == rs_address_d) ||
                        (uses_rt_d && (write_reg_e == rt_address_d)));

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_drain_cnt;
      w_stall      = 1'b0;
      w_hold       = 1'b0;
      w_flush      = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_load_use) begin
               w_stall = 1'b1;
               w_hold  = 1'b1;
            end else begin
               w_flush = branch_taken_d || halt_d;
               if (halt_d) begin
                  w_next_state = ST_DRAIN;
                  w_next_cnt   = DRAIN_INIT;
               end
            end
         end
         ST_DRAIN: begin
            // Older instructions keep flowing; only the front end is frozen.
            w_hold  = 1'b1;
            w_flush = 1'b1;
            if (r_drain_cnt == '0)
               w_next_state = ST_HALTED;
            else
               w_next_cnt = r_drain_cnt - 1'b1;
         end
         ST_HALTED: begin
            w_hold  = 1'b1;
            w_flush = 1'b1;
         end
         default: w_next_state = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RUN;
         r_drain_cnt  <= '0;
         r_cpu_halted <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_drain_cnt  <= w_next_cnt;
         r_cpu_halted <= (w_next_state == ST_HALTED);
      end
   end

   forward_unit #(.REG_AW(REG_AW)) u_fwd (
      .i_rs_e        (rs_address_e),
      .i_rt_e        (rt_address_e),
      .i_reg_write_m (reg_write_m),
      .i_write_reg_m (write_reg_m),
      .i_reg_write_w (reg_write_w),
      .i_write_reg_w (write_reg_w),
      .o_forward_a   (w_fwd_a),
      .o_forward_b   (w_fwd_b)
   );

   // Combinational outputs are forced low for the whole time reset is held.
   assign sig_stall   = w_stall & ~reset;
   assign pc_hold     = w_hold  & ~reset;
   assign sig_flush   = w_flush & ~reset;
   assign forward_a_e = w_fwd_a & {2{~reset}};
   assign forward_b_e = w_fwd_b & {2{~reset}};
   assign cpu_halted  = r_cpu_halted;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
`endif

   logic w_unused;
   assign w_unused = w_unused_rw_e;

endmodule
